// File: rtl/key_pkg.sv
// Shared types and constants for the front-panel key scheduler.
package key_pkg;

    localparam int KEY_CODE_W = 3;

    typedef logic [KEY_CODE_W-1:0] key_code_t;

    localparam key_code_t KEY_NONE = 3'd0;
    localparam key_code_t KEY_E    = 3'd1;
    localparam key_code_t KEY_U    = 3'd2;
    localparam key_code_t KEY_D    = 3'd3;
    localparam key_code_t KEY_L    = 3'd4;
    localparam key_code_t KEY_R    = 3'd5;

    typedef enum logic [2:0] {
        ARM          = 3'd0,
        IDLE         = 3'd1,
        PRESS_WAIT   = 3'd2,
        HELD         = 3'd3,
        RELEASE_WAIT = 3'd4,
        EMIT         = 3'd5
    } key_state_e;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for one raw active-low key; resets to released (1).
import key_pkg::*;

module key_sync (
    input  logic clkin,
    input  logic rst,
    input  logic k_raw,
    output logic k_sync
);

    logic meta;

    // Double-register the asynchronous key level into the clkin domain.
    always_ff @(posedge clkin) begin
        if (rst) begin
            meta   <= 1'b1;
            k_sync <= 1'b1;
        end else begin
            meta   <= k_raw;
            k_sync <= meta;
        end
    end

endmodule

// File: rtl/key_event_scheduler.sv
// Five-key scheduler sharing one debounce counter; one event per press+release.
// Optional auto-repeat for ku/kd is enabled by defining KEY_AUTOREPEAT_EN.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ARM          | after reset; wait for synchronizers to settle, all keys up
// IDLE         | no owner; pick highest-priority pressed key
// PRESS_WAIT   | owner low; count DEBOUNCE_CYCLES to confirm the press
// HELD         | press confirmed; wait for owner to rise (repeat timer here)
// RELEASE_WAIT | owner high; count DEBOUNCE_CYCLES to confirm the release
// EMIT         | release confirmed; key_evt is raised on the next cycle
import key_pkg::*;

module key_event_scheduler #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                  clkin,
    input  logic                  rst,
    input  logic                  ke,
    input  logic                  ku,
    input  logic                  kd,
    input  logic                  kl,
    input  logic                  kr,
    output logic                  key_evt,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_busy
);

    localparam logic [2:0] S_ARM          = ARM;
    localparam logic [2:0] S_IDLE         = IDLE;
    localparam logic [2:0] S_PRESS_WAIT   = PRESS_WAIT;
    localparam logic [2:0] S_HELD         = HELD;
    localparam logic [2:0] S_RELEASE_WAIT = RELEASE_WAIT;
    localparam logic [2:0] S_EMIT         = EMIT;

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizer outputs look released for two cycles after reset; ARM
    // must not trust them before that or a key held through reset leaks out.
    localparam logic [1:0] SETTLE_DONE = 2'd2;

    logic [4:0]       k_sync;
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       settle_q;
    key_code_t        owner;
    key_code_t        winner;
    logic             owner_lvl;
    logic             cnt_en;
    logic             fire_rpt;
    logic             rpt_fired;
    logic             evt_d;

    key_sync u_sync_e (.clkin(clkin), .rst(rst), .k_raw(ke), .k_sync(k_sync[0]));
    key_sync u_sync_u (.clkin(clkin), .rst(rst), .k_raw(ku), .k_sync(k_sync[1]));
    key_sync u_sync_d (.clkin(clkin), .rst(rst), .k_raw(kd), .k_sync(k_sync[2]));
    key_sync u_sync_l (.clkin(clkin), .rst(rst), .k_raw(kl), .k_sync(k_sync[3]));
    key_sync u_sync_r (.clkin(clkin), .rst(rst), .k_raw(kr), .k_sync(k_sync[4]));

    // Fixed-priority arbiter: ke > ku > kd > kl > kr.
    always_comb begin
        winner = KEY_NONE;
        if      (!k_sync[0]) winner = KEY_E;
        else if (!k_sync[1]) winner = KEY_U;
        else if (!k_sync[2]) winner = KEY_D;
        else if (!k_sync[3]) winner = KEY_L;
        else if (!k_sync[4]) winner = KEY_R;
    end

    // Level of the key currently being served; non-owners are invisible here.
    always_comb begin
        owner_lvl = 1'b1;
        case (owner)
            KEY_E:   owner_lvl = k_sync[0];
            KEY_U:   owner_lvl = k_sync[1];
            KEY_D:   owner_lvl = k_sync[2];
            KEY_L:   owner_lvl = k_sync[3];
            KEY_R:   owner_lvl = k_sync[4];
            default: owner_lvl = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ARM: begin
                if (settle_q == SETTLE_DONE && (&k_sync)) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (winner != KEY_NONE) state_d = S_PRESS_WAIT;
            end
            S_PRESS_WAIT: begin
                if (owner_lvl)              state_d = S_IDLE;
                else if (cnt_q == CNT_LAST) state_d = S_HELD;
            end
            S_HELD: begin
                if (owner_lvl) state_d = S_RELEASE_WAIT;
            end
            S_RELEASE_WAIT: begin
                if (!owner_lvl)             state_d = S_HELD;
                else if (cnt_q == CNT_LAST) state_d = rpt_fired ? S_IDLE : S_EMIT;
            end
            S_EMIT: begin
                state_d = S_IDLE;
            end
            default: state_d = S_ARM;
        endcase
    end

    assign cnt_en = (state_q == S_PRESS_WAIT && !owner_lvl) ||
                    (state_q == S_RELEASE_WAIT && owner_lvl);

    // State, owner latch, settle counter and the shared debounce counter.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q  <= S_ARM;
            owner    <= KEY_NONE;
            cnt_q    <= '0;
            settle_q <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && winner != KEY_NONE) owner <= winner;
            if (state_d != state_q) cnt_q <= '0;
            else if (cnt_en)        cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == S_ARM) begin
                if (settle_q != SETTLE_DONE) settle_q <= settle_q + 2'd1;
            end else begin
                settle_q <= 2'd0;
            end
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_tmr;
    logic             rpt_key;

    assign rpt_key  = (owner == KEY_U) || (owner == KEY_D);
    assign fire_rpt = (state_q == S_HELD) && rpt_key && (rpt_tmr == '0);

    // Hold timer: armed during the press debounce so a release bounce back
    // into HELD continues the running schedule instead of restarting it.
    always_ff @(posedge clkin) begin
        if (rst) begin
            rpt_tmr   <= '0;
            rpt_fired <= 1'b0;
        end else if (state_q == S_PRESS_WAIT) begin
            rpt_tmr   <= RPT_W'(REPEAT_DELAY - 1);
            rpt_fired <= 1'b0;
        end else if (state_q == S_HELD && rpt_key) begin
            if (rpt_tmr == '0) begin
                rpt_tmr   <= RPT_W'(REPEAT_PERIOD - 1);
                rpt_fired <= 1'b1;
            end else begin
                rpt_tmr <= rpt_tmr - RPT_W'(1);
            end
        end
    end
`else
    localparam int unused_rpt_params = REPEAT_DELAY + REPEAT_PERIOD;

    assign fire_rpt  = 1'b0;
    assign rpt_fired = 1'b0;
`endif

    assign evt_d = (state_q == S_EMIT) || fire_rpt;

    // Registered event pulse; key_code only moves together with key_evt.
    always_ff @(posedge clkin) begin
        if (rst) begin
            key_evt  <= 1'b0;
            key_code <= KEY_NONE;
        end else begin
            key_evt <= evt_d;
            if (evt_d) key_code <= owner;
        end
    end

    assign key_busy = (state_q != S_IDLE);

endmodule
